// File: rtl/xnor_arb_pkg.sv
// Shared types and constants for the round-robin XNOR/equality arbiter.
// The XNOR_ARB_STATS_EN macro (used by the top) enables the mismatch counter.
package xnor_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/xnorgate.sv
// Single-bit XNOR gate; the one shared datapath element time-multiplexed by the arbiter.
module xnorgate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/xnor_cmp_arbiter.sv
// Round-robin arbiter streaming one requester's operands LSB-first through a shared xnorgate.
// Define XNOR_ARB_STATS_EN to build the saturating mismatch counter behind err_cnt.
module xnor_cmp_arbiter
  import xnor_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      xnor_out,
  output logic                  eq,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int              KW       = $clog2(WIDTH) + 1;
  localparam int              PW       = $clog2(NREQ);
  localparam logic [KW-1:0]   K_LAST   = KW'(WIDTH - 1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(NREQ - 1);

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, idx_q, idx_d;
  logic [KW-1:0]     k_q;
  logic [NREQ-1:0]   gnt_d;
  logic [WIDTH-1:0]  a_q, b_q, acc_q, acc_next, a_sel, b_sel;
  logic              gate_y;
  logic              last_bit;
  int                pick;

  // First set request at or above ptr, wrapping; closest distance wins.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] ptr);
    int best_d;
    int d;
    rr_pick = 0;
    best_d  = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - int'(ptr)) % NREQ;
      if (r[i] && d < best_d) begin
        best_d  = d;
        rr_pick = i;
      end
    end
  endfunction

  always_comb begin
    pick  = rr_pick(req, ptr_q);
    gnt_d = '0;
    idx_d = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == pick) begin
        gnt_d[i] = 1'b1;
        idx_d    = PW'(i);
        a_sel    = a_bus[i*WIDTH +: WIDTH];
        b_sel    = b_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  xnorgate u_gate (
    .a (a_q[0]),
    .b (b_q[0]),
    .y (gate_y)
  );

  // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  assign acc_next = (acc_q >> 1) | (WIDTH'(gate_y) << (WIDTH - 1));
  assign last_bit = (state_q == SHIFT) && (k_q == K_LAST);
  assign done     = (state_q == DONE);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = SHIFT;
      SHIFT:   if (k_q == K_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt      <= '0;
      busy     <= 1'b0;
      xnor_out <= '0;
      eq       <= 1'b0;
      ptr_q    <= '0;
      idx_q    <= '0;
      k_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt   <= gnt_d;
            busy  <= 1'b1;
            idx_q <= idx_d;
            k_q   <= '0;
          end
        end
        SHIFT: begin
          k_q <= k_q + 1'b1;
          if (last_bit) begin
            xnor_out <= acc_next;
            eq       <= &acc_next;
          end
        end
        DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          ptr_q <= (idx_q == PTR_LAST) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand/accumulator registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      a_q <= a_sel;
      b_q <= b_sel;
    end else if (state_q == SHIFT) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      acc_q <= acc_next;
    end
  end

`ifdef XNOR_ARB_STATS_EN
  logic [ERR_CNT_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (last_bit && !(&acc_next) && err_q != ERR_CNT_MAX) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_xnor_cmp_arbiter.sv
// Self-checking bench for xnor_cmp_arbiter: randomized traffic against a transaction-level model.
module tb_xnor_cmp_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BW    = NREQ * WIDTH;
`ifdef XNOR_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [BW-1:0]    a_bus, b_bus;
  logic [NREQ-1:0]  gnt;
  logic             busy, done;
  logic [WIDTH-1:0] xnor_out;
  logic             eq;
  logic [7:0]       err_cnt;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int m_err  = 0;

  always #5 clk = ~clk;

  xnor_cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_bus    (a_bus),
    .b_bus    (b_bus),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .xnor_out (xnor_out),
    .eq       (eq),
    .err_cnt  (err_cnt)
  );

  // Reference model: which requester wins, and what the stats counter should read.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int j = 0; j < NREQ; j++)
      if (r[(m_ptr + j) % NREQ]) return (m_ptr + j) % NREQ;
    return 0;
  endfunction

  function automatic void model_commit(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    m_ptr = (i + 1) % NREQ;
    if (STATS_EN && a != b && m_err < 255) m_err++;
  endfunction

  task automatic apply_reset;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_err = 0;
  endtask

  // Drives one transaction from a negedge and reports what the DUT did; ends on a negedge.
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [BW-1:0] av, input logic [BW-1:0] bv,
                         input bit hold, input bit scramble,
                         output logic [NREQ-1:0] g, output int lat, output logic [WIDTH-1:0] x,
                         output logic e, output logic d2, output bit bad, output bit to);
    int n;
    g = '0; lat = 0; x = '0; e = 1'b0; d2 = 1'b0; bad = 1'b0; to = 1'b0;
    req = r; a_bus = av; b_bus = bv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 20);
    if (gnt == '0) begin
      to = 1'b1;
      return;
    end
    g = gnt;
    if (scramble) begin
      a_bus = BW'($urandom);
      b_bus = BW'($urandom);
    end
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (gnt !== g) bad = 1'b1;
    end
    if (!done) begin
      to = 1'b1;
      return;
    end
    x = xnor_out;
    e = eq;
    if (!hold) req = req & ~g;
    @(negedge clk);
    d2 = done;
  endtask

  function automatic logic [BW-1:0] rand_bus();
    return BW'($urandom);
  endfunction

  task automatic test_reset;
    apply_reset;
    checks++; if (gnt !== '0)      begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (xnor_out !== '0) begin errors++; $display("FAIL reset_xnor: got %h want 00", xnor_out); end
    checks++; if (eq !== 1'b0)     begin errors++; $display("FAIL reset_eq: got %b want 0", eq); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
  endtask

  task automatic test_directed;
    logic [NREQ-1:0]  r_t [3] = '{4'b0001, 4'b0010, 4'b0010};
    logic [WIDTH-1:0] a_t [3] = '{8'hA5, 8'h0F, 8'h3C};
    logic [WIDTH-1:0] b_t [3] = '{8'hA5, 8'hF0, 8'h3D};
    logic [WIDTH-1:0] x_t [3] = '{8'hFF, 8'h00, 8'hFE};
    logic             e_t [3] = '{1'b1, 1'b0, 1'b0};
    logic [NREQ-1:0] g; int lat; logic [WIDTH-1:0] x; logic e, d2; bit bad, to;
    logic [BW-1:0] av, bv; int i;
    for (int t = 0; t < 3; t++) begin
      i  = model_pick(r_t[t]);
      av = rand_bus(); bv = rand_bus();
      av[i*WIDTH +: WIDTH] = a_t[t];
      bv[i*WIDTH +: WIDTH] = b_t[t];
      run_txn(r_t[t], av, bv, 1'b0, 1'b0, g, lat, x, e, d2, bad, to);
      model_commit(i, a_t[t], b_t[t]);
      checks++; if (to || g !== r_t[t]) begin errors++; $display("FAIL dir_gnt[%0d]: got %b want %b timeout=%0d", t, g, r_t[t], to); end
      checks++; if (lat != WIDTH) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", t, lat, WIDTH); end
      checks++; if (x !== x_t[t] || e !== e_t[t]) begin errors++; $display("FAIL dir_result[%0d]: got %h/%b want %h/%b", t, x, e, x_t[t], e_t[t]); end
      checks++; if (d2 !== 1'b0 || bad) begin errors++; $display("FAIL dir_pulse[%0d]: done2=%b gnt_changed=%0d want 0/0", t, d2, bad); end
      checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL dir_err_cnt[%0d]: got %0d want %0d", t, err_cnt, m_err); end
    end
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] g; int lat; logic [WIDTH-1:0] x; logic e, d2; bit bad, to;
    logic [BW-1:0] av, bv; logic [WIDTH-1:0] ea, eb; int i;
    apply_reset;
    for (int t = 0; t < 5; t++) begin
      i  = model_pick(4'b1111);
      av = rand_bus();
      bv = ($urandom_range(0, 1) == 0) ? av : rand_bus();
      ea = av[i*WIDTH +: WIDTH]; eb = bv[i*WIDTH +: WIDTH];
      run_txn(4'b1111, av, bv, 1'b1, 1'b0, g, lat, x, e, d2, bad, to);
      model_commit(i, ea, eb);
      checks++; if (to || g !== NREQ'(1 << order[t])) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want onehot(%0d)", t, g, order[t]); end
      checks++; if (x !== ~(ea ^ eb) || e !== (ea == eb)) begin errors++; $display("FAIL rr_result[%0d]: got %h/%b want %h/%b", t, x, e, ~(ea ^ eb), ea == eb); end
      checks++; if (d2 !== 1'b0 || bad || lat != WIDTH) begin errors++; $display("FAIL rr_pulse[%0d]: done2=%b gnt_changed=%0d lat=%0d", t, d2, bad, lat); end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_ptr_and_capture;
    logic [NREQ-1:0] r_t [3] = '{4'b0001, 4'b0101, 4'b0001};
    int              w_t [3] = '{0, 2, 0};
    logic [NREQ-1:0] g; int lat; logic [WIDTH-1:0] x; logic e, d2; bit bad, to;
    logic [BW-1:0] av, bv; logic [WIDTH-1:0] ea, eb; int i;
    apply_reset;
    for (int t = 0; t < 3; t++) begin
      i  = model_pick(r_t[t]);
      av = rand_bus(); bv = rand_bus();
      ea = av[i*WIDTH +: WIDTH]; eb = bv[i*WIDTH +: WIDTH];
      run_txn(r_t[t], av, bv, 1'b0, t > 0, g, lat, x, e, d2, bad, to);
      model_commit(i, ea, eb);
      checks++; if (to || g !== NREQ'(1 << w_t[t])) begin errors++; $display("FAIL ptr_gnt[%0d]: got %b want onehot(%0d)", t, g, w_t[t]); end
      checks++; if (x !== ~(ea ^ eb) || e !== (ea == eb)) begin errors++; $display("FAIL capture_result[%0d]: got %h/%b want %h/%b", t, x, e, ~(ea ^ eb), ea == eb); end
    end
  endtask

  task automatic test_random;
    logic [NREQ-1:0] g, r; int lat; logic [WIDTH-1:0] x; logic e, d2; bit bad, to;
    logic [BW-1:0] av, bv; logic [WIDTH-1:0] ea, eb; int i;
    for (int t = 0; t < 40; t++) begin
      r  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      i  = model_pick(r);
      av = rand_bus();
      bv = ($urandom_range(0, 3) == 0) ? av : rand_bus();
      ea = av[i*WIDTH +: WIDTH]; eb = bv[i*WIDTH +: WIDTH];
      run_txn(r, av, bv, 1'b0, $urandom_range(0, 1) == 1, g, lat, x, e, d2, bad, to);
      model_commit(i, ea, eb);
      req = '0;
      checks++; if (to || g !== NREQ'(1 << i)) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want onehot(%0d) req=%b", t, g, i, r); end
      checks++; if (x !== ~(ea ^ eb) || e !== (ea == eb)) begin errors++; $display("FAIL rand_result[%0d]: got %h/%b want %h/%b", t, x, e, ~(ea ^ eb), ea == eb); end
      checks++; if (d2 !== 1'b0 || bad || lat != WIDTH) begin errors++; $display("FAIL rand_pulse[%0d]: done2=%b gnt_changed=%0d lat=%0d", t, d2, bad, lat); end
      checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL rand_err_cnt[%0d]: got %0d want %0d", t, err_cnt, m_err); end
    end
  endtask

  task automatic test_reset_mid;
    logic [NREQ-1:0] g; int lat; logic [WIDTH-1:0] x; logic e, d2; bit bad, to;
    logic [BW-1:0] av, bv; logic [WIDTH-1:0] ea, eb; int n; bit seen;
    apply_reset;
    run_txn(4'b0010, '0, '0, 1'b0, 1'b0, g, lat, x, e, d2, bad, to);
    checks++; if (to || xnor_out !== 8'hFF) begin errors++; $display("FAIL pre_reset_result: got %h want ff", xnor_out); end
    req = 4'b0001; a_bus = rand_bus(); b_bus = ~a_bus;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 20);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b want 0001", gnt); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== '0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: gnt=%b busy=%b done=%b want 0", gnt, busy, done); end
    checks++; if (xnor_out !== '0 || eq !== 1'b0 || err_cnt !== 8'h00) begin errors++; $display("FAIL midrst_data: xnor=%h eq=%b err=%h want 0", xnor_out, eq, err_cnt); end
    rst_n = 1'b1; req = '0; m_ptr = 0; m_err = 0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_done: got activity want none"); end
    av = rand_bus(); bv = rand_bus();
    ea = av[2*WIDTH +: WIDTH]; eb = bv[2*WIDTH +: WIDTH];
    run_txn(4'b0100, av, bv, 1'b0, 1'b0, g, lat, x, e, d2, bad, to);
    model_commit(2, ea, eb);
    checks++; if (to || g !== 4'b0100 || lat != WIDTH) begin errors++; $display("FAIL rerequest_gnt: got %b lat=%0d want 0100 lat=%0d", g, lat, WIDTH); end
    checks++; if (x !== ~(ea ^ eb) || e !== (ea == eb)) begin errors++; $display("FAIL rerequest_result: got %h/%b want %h/%b", x, e, ~(ea ^ eb), ea == eb); end
  endtask

  task automatic test_stats;
    bit mis_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [NREQ-1:0] g; int lat; logic [WIDTH-1:0] x; logic e, d2; bit bad, to;
    logic [BW-1:0] av, bv; int n_to;
    apply_reset;
    n_to = 0;
    for (int t = 0; t < 5; t++) begin
      av = rand_bus();
      bv = mis_t[t] ? (av ^ BW'(32'h0100_0000 << ($urandom_range(0, 7)))) : av;
      run_txn(4'b1000, av, bv, 1'b0, 1'b0, g, lat, x, e, d2, bad, to);
      if (to) n_to++;
    end
    if (STATS_EN) begin
      checks++; if (n_to != 0 || err_cnt !== 8'd3) begin errors++; $display("FAIL stats_three: got %0d want 3 timeouts=%0d", err_cnt, n_to); end
      for (int t = 0; t < 300; t++) begin
        av = rand_bus();
        bv = ~av;
        run_txn(4'b1000, av, bv, 1'b0, 1'b0, g, lat, x, e, d2, bad, to);
        if (to) n_to++;
      end
      checks++; if (n_to != 0 || err_cnt !== 8'hFF) begin errors++; $display("FAIL stats_saturate: got %h want ff timeouts=%0d", err_cnt, n_to); end
    end else begin
      checks++; if (n_to != 0 || err_cnt !== 8'h00) begin errors++; $display("FAIL stats_disabled: got %h want 00 timeouts=%0d", err_cnt, n_to); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_round_robin;
    test_ptr_and_capture;
    test_random;
    test_reset_mid;
    test_stats;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
